rsqrt_seed: RTL and testbench
=============================

RSQRT_SEED -- requirements
Module: rsqrt_seed

Interface
REQ-001 Parameter IW, default 16, integer bits of the sfp format (sign included).
REQ-002 Parameter QW, default 16, fraction bits of the sfp format; W = IW+QW.
REQ-003 Parameter LUT_BITS, default 4, mantissa bits indexing the seed table.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle pulse qualifying in.val; one operand per cycle maximum.
REQ-007 in  sfp_if.in  W  operand S, signed fixed-point IW.QW.
REQ-008 valid  output  1  high for one cycle per result; est, s_out and err are valid in that cycle.
REQ-009 est  sfp_if.out  W  seed y0 ~ 1/sqrt(S); drives the Goldschmidt stage est input.
REQ-010 s_out  sfp_if.out  W  S delayed to align with est; drives the Goldschmidt stage in input.
REQ-011 err  output  1  S <= 0 for the current result.

Function
REQ-012 The block SHALL be a 3-stage pipeline: valid asserts exactly 3 cycles after start; throughput 1 result/cycle; no backpressure.
REQ-013 Stage 1 SHALL register S and p = index of the leading one of S (bit 0..W-1), plus flag S<=0.
REQ-014 Stage 2 SHALL compute e = p - QW, k = floor(e/2) (arithmetic), and register LUT[{e[0], LUT_BITS bits directly below the leading one}].
REQ-015 Missing low bits below the leading one (p < LUT_BITS) SHALL read as zero.
REQ-016 LUT entry SHALL equal round(2^QW / sqrt(m_lo)), m_lo = lower edge of the bucket, m in [1,2) for e even, [2,4) for e odd.
REQ-017 Stage 3 SHALL produce est = entry >>> k for k >= 0, entry << -k for k < 0, saturating to 2^(W-1)-1 on overflow.
REQ-018 S <= 0 SHALL give est = 2^(W-1)-1 and err = 1; otherwise err = 0.
REQ-019 s_out SHALL equal the S whose start occurred 3 cycles earlier.
REQ-020 Data registers of a stage SHALL load only when that stage's valid bit is set; they hold otherwise.
REQ-021 Back-to-back starts SHALL yield back-to-back valid pulses with results in order, no mixing between operands.
REQ-022 Combinational path start->valid or in->est SHALL NOT exist.

Reset
REQ-023 resetn low SHALL clear the 3-bit valid shift register asynchronously; valid = 0 during reset.
REQ-024 Data registers (est, s_out, err, intermediates) SHALL NOT be reset; their values are don't-care while valid = 0.
REQ-025 Reset mid-operation SHALL discard all in-flight operands; no valid pulse for starts issued before resetn rose.
REQ-026 First valid after reset SHALL be 3 cycles after the first start sampled with resetn high.

Structure
REQ-027 LUT_BITS default, the LUT contents (generated by a function of IW, QW, LUT_BITS) and the saturation constant SHALL live in the shared sfp package.
REQ-028 Leading-one detection SHALL be a separate combinational sub-module sfp_lzc (W-bit input, index and zero-flag outputs).
REQ-029 The block SHALL instantiate no multipliers; shifts and the table only.

Verification (IW=16, QW=16)
REQ-030 S=0x0001_0000 (1.0), start pulse -> 3 cycles later valid=1, est=0x0001_0000, s_out=0x0001_0000, err=0.
REQ-031 S=0x0004_0000 (4.0) -> est=0x0000_8000 (0.5); S=0x0000_4000 (0.25) -> est=0x0002_0000 (2.0).
REQ-032 S=0x0002_0000 (2.0) -> est=0x0000_B505; S=0x0000_0001 -> est=0x0100_0000.
REQ-033 S=0 then S=0xFFFF_0000 (-1.0) -> est=0x7FFF_FFFF, err=1 for both.
REQ-034 Starts on 5 consecutive cycles with S = 1.0, 4.0, 0.25, 2.0, 0 -> 5 consecutive valid pulses with the expected est values in order.
REQ-035 Two starts in flight, resetn pulsed low -> no valid pulse; next start after release -> valid exactly 3 cycles later with the correct est.

Source files
------------

// File: rtl/sfp_pkg.sv
// Shared signed fixed-point (sfp) helpers: seed-table generator, saturation
// constant and default table resolution for the reciprocal-square-root seed.
package sfp_pkg;

    // Mantissa bits below the leading one that index the seed table.
    localparam int LUT_BITS_DEF = 4;

    // Largest positive value of a w-bit two's-complement word.
    function automatic logic [127:0] sfp_sat(input int w);
        return (128'd1 << (w - 1)) - 128'd1;
    endfunction

    // Seed entry round(2^qw / sqrt(m_lo)). The top index bit selects the
    // [2,4) half (odd exponent); the low lut_bits give the bucket within
    // [1,2). Rounding is exact: the largest y with (2y-1)^2 * m_lo <= 4 * 2^(2qw)
    // is found bit by bit. Used only with constant arguments at elaboration.
    function automatic logic [127:0] rsqrt_lut_entry(input int qw, input int lut_bits,
                                                     input int idx);
        logic [127:0] num;
        logic [127:0] lim;
        logic [127:0] y;
        logic [127:0] c;
        logic [127:0] t;
        num = 128'((1 << lut_bits) + (idx % (1 << lut_bits)));
        if (idx >= (1 << lut_bits)) begin
            num = num << 1;
        end else begin
            num = num;
        end
        lim = 128'd1 << (2 * qw + lut_bits + 2);
        y   = 128'd0;
        for (int b = qw + 1; b >= 0; b--) begin
            c = y | (128'd1 << b);
            t = (c << 1) - 128'd1;
            if ((t * t * num) <= lim) begin
                y = c;
            end else begin
                y = y;
            end
        end
        return y;
    endfunction

endpackage

// File: rtl/sfp_lzc.sv
// Leading-one detector: index of the most significant set bit and an
// all-zero flag. Purely combinational.
module sfp_lzc #(
    parameter int W = 32
) (
    input  logic [W-1:0]         din,
    output logic [$clog2(W)-1:0] idx,
    output logic                 zero
);

    // Scan upward so the highest set bit wins.
    always_comb begin
        idx  = '0;
        zero = ~|din;
        for (int i = 0; i < W; i++) begin
            idx = din[i] ? ($clog2(W))'(i) : idx;
        end
    end

endmodule

// File: rtl/rsqrt_seed.sv
// Three-stage reciprocal-square-root seed for a Goldschmidt iteration.
// Stage 1 normalises (leading one), stage 2 looks up the mantissa seed,
// stage 3 applies the exponent as a shift with saturation.
module rsqrt_seed
    import sfp_pkg::*;
#(
    parameter int IW       = 16,
    parameter int QW       = 16,
    parameter int LUT_BITS = LUT_BITS_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [IW+QW-1:0]   in,
    output logic               valid,
    output logic [IW+QW-1:0]   est,
    output logic [IW+QW-1:0]   s_out,
    output logic               err
);

    localparam int W     = IW + QW;
    localparam int PW    = $clog2(W);
    localparam int EW    = PW + 2;
    localparam int ENT_W = QW + 2;
    localparam int WIDE  = W + ENT_W;
    localparam int LUT_N = 2 ** (LUT_BITS + 1);
    localparam logic [W-1:0]         SAT  = W'(sfp_sat(W));
    localparam logic signed [EW-1:0] QW_E = EW'(QW);

    logic [2:0]             vld_r;
    logic [PW-1:0]          p_s;
    logic                   zero_s;

    logic [W-1:0]           s1_s_r;
    logic [PW-1:0]          s1_p_r;
    logic                   s1_np_r;

    logic signed [EW-1:0]   e_s;
    logic signed [EW-1:0]   k_s;
    logic [LUT_BITS-1:0]    frac_s;
    logic [LUT_BITS:0]      idx_s;
    logic [ENT_W-1:0]       lut_s [LUT_N];

    logic [ENT_W-1:0]       s2_entry_r;
    logic signed [EW-1:0]   s2_k_r;
    logic [W-1:0]           s2_s_r;
    logic                   s2_np_r;

    logic [EW-1:0]          kmag_s;
    logic [WIDE-1:0]        wide_s;
    logic [W-1:0]           shifted_s;

    // Seed table is constant; every entry is computed at elaboration.
    for (genvar g = 0; g < LUT_N; g++) begin : g_lut
        assign lut_s[g] = ENT_W'(rsqrt_lut_entry(QW, LUT_BITS, g));
    end

    sfp_lzc #(.W(W)) u_lzc (
        .din  (in),
        .idx  (p_s),
        .zero (zero_s)
    );

    // Valid shift register; the only state cleared by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_r <= 3'b000;
        end else begin
            vld_r <= {vld_r[1:0], start};
        end
    end

    // Stage 1: capture operand, leading-one position and non-positive flag.
    always_ff @(posedge clk) begin
        if (start) begin
            s1_s_r  <= in;
            s1_p_r  <= p_s;
            s1_np_r <= zero_s | in[W-1];
        end
    end

    // Stage 2 decode: exponent, half exponent, and the bits just below the
    // leading one (zero-filled when the operand has too few low bits).
    always_comb begin
        e_s    = $signed({2'b00, s1_p_r}) - QW_E;
        k_s    = e_s >>> 1;
        frac_s = LUT_BITS'({s1_s_r, {LUT_BITS{1'b0}}} >> s1_p_r);
        idx_s  = {e_s[0], frac_s};
    end

    // Stage 2: register the table seed and the shift that goes with it.
    always_ff @(posedge clk) begin
        if (vld_r[0]) begin
            s2_entry_r <= lut_s[idx_s];
            s2_k_r     <= k_s;
            s2_s_r     <= s1_s_r;
            s2_np_r    <= s1_np_r;
        end
    end

    // Stage 3 datapath: scale the seed by 2^-k and clamp to the top value.
    always_comb begin
        kmag_s = s2_k_r[EW-1] ? EW'(-s2_k_r) : EW'(s2_k_r);
        if (s2_k_r[EW-1]) begin
            wide_s = WIDE'(s2_entry_r) << kmag_s;
        end else begin
            wide_s = WIDE'(s2_entry_r) >> kmag_s;
        end
        if (wide_s > WIDE'(SAT)) begin
            shifted_s = SAT;
        end else begin
            shifted_s = wide_s[W-1:0];
        end
    end

    // Stage 3: registered results; non-positive operands report the clamp.
    always_ff @(posedge clk) begin
        if (vld_r[1]) begin
            est   <= s2_np_r ? SAT : shifted_s;
            s_out <= s2_s_r;
            err   <= s2_np_r;
        end
    end

    assign valid = vld_r[2];

endmodule

// File: tb/tb_rsqrt_seed.sv
// Directed self-checking bench for rsqrt_seed (IW=16, QW=16, LUT_BITS=4).
module tb_rsqrt_seed;

    localparam logic [31:0] SATV = 32'h7FFF_FFFF;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [31:0] in_r;
    logic        valid;
    logic [31:0] est;
    logic [31:0] s_out;
    logic        err;

    int n_checks;
    int n_errors;

    rsqrt_seed #(.IW(16), .QW(16), .LUT_BITS(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .in     (in_r),
        .valid  (valid),
        .est    (est),
        .s_out  (s_out),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        resetn = 1'b0;
        start  = 1'b0;
        in_r   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_hold: valid=%b expected 0", valid);
        end
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (valid !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_idle%0d: valid=%b expected 0", i, valid);
            end
        end
    endtask

    task automatic test_values();
        logic [31:0] s_tab [11];
        logic [31:0] e_tab [11];
        logic        r_tab [11];
        s_tab = '{32'h0001_0000, 32'h0004_0000, 32'h0000_4000, 32'h0002_0000,
                  32'h0000_0001, 32'h0003_0000, 32'h0001_8000, 32'h0000_8000,
                  32'h4000_0000, 32'h0000_0000, 32'hFFFF_0000};
        e_tab = '{32'h0001_0000, 32'h0000_8000, 32'h0002_0000, 32'h0000_B505,
                  32'h0100_0000, 32'h0000_93CD, 32'h0000_D106, 32'h0001_6A0A,
                  32'h0000_0200, SATV, SATV};
        r_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 11; i++) begin
            in_r  = s_tab[i];
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            in_r  = 32'hDEAD_BEEF;
            @(posedge clk);
            #1;
            n_checks++;
            if (valid !== 1'b0) begin
                n_errors++;
                $display("FAIL early_valid%0d: valid=%b expected 0", i, valid);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (valid !== 1'b1 || est !== e_tab[i] || s_out !== s_tab[i] || err !== r_tab[i]) begin
                n_errors++;
                $display("FAIL value%0d S=%h: valid=%b est=%h s_out=%h err=%b expected valid=1 est=%h s_out=%h err=%b",
                         i, s_tab[i], valid, est, s_out, err, e_tab[i], s_tab[i], r_tab[i]);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (valid !== 1'b0) begin
                n_errors++;
                $display("FAIL single_pulse%0d: valid=%b expected 0", i, valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] s_tab [5];
        logic [31:0] e_tab [5];
        logic        r_tab [5];
        s_tab = '{32'h0001_0000, 32'h0004_0000, 32'h0000_4000, 32'h0002_0000, 32'h0000_0000};
        e_tab = '{32'h0001_0000, 32'h0000_8000, 32'h0002_0000, 32'h0000_B505, SATV};
        r_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int c = 0; c < 10; c++) begin
            start = (c < 5);
            in_r  = (c < 5) ? s_tab[c] : 32'h1234_5678;
            @(posedge clk);
            #1;
            n_checks++;
            if (c >= 2 && c < 7) begin
                if (valid !== 1'b1 || est !== e_tab[c-2] || s_out !== s_tab[c-2] || err !== r_tab[c-2]) begin
                    n_errors++;
                    $display("FAIL b2b_cycle%0d: valid=%b est=%h s_out=%h err=%b expected valid=1 est=%h s_out=%h err=%b",
                             c, valid, est, s_out, err, e_tab[c-2], s_tab[c-2], r_tab[c-2]);
                end
            end else begin
                if (valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL b2b_idle%0d: valid=%b expected 0", c, valid);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_midflight();
        in_r  = 32'h0001_0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        in_r  = 32'h0004_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (valid !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_async: valid=%b expected 0", valid);
        end
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (valid !== 1'b0) begin
                n_errors++;
                $display("FAIL midreset_low%0d: valid=%b expected 0", i, valid);
            end
        end
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (valid !== 1'b0) begin
                n_errors++;
                $display("FAIL after_release%0d: valid=%b expected 0", i, valid);
            end
        end
        in_r  = 32'h0000_4000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (valid !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_early: valid=%b expected 0", valid);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (valid !== 1'b1 || est !== 32'h0002_0000 || s_out !== 32'h0000_4000 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_result: valid=%b est=%h s_out=%h err=%b expected valid=1 est=00020000 s_out=00004000 err=0",
                     valid, est, s_out, err);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (valid !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_pulse: valid=%b expected 0", valid);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_values();
        test_back_to_back();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
